// File: rtl/modulus_seq_ctrl.sv
// modulus_seq_ctrl: command-driven sequencer for the 6-bit modulus counter.
// Commands of {modulus, passes-1} are queued in a small FIFO and executed
// in order. Each command runs the counter 0..M-1 for rep+1 passes.
// Optional feature macro: MODSEQ_ABORT_EN adds an 'abort' input that
// terminates the running command early.
module modulus_seq_ctrl #(
  parameter int CW    = 6,
  parameter int RW    = 4,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [CW-1:0] cmd_mod,
  input  logic [RW-1:0] cmd_rep,
`ifdef MODSEQ_ABORT_EN
  input  logic          abort,
`endif
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          cmd_done,
  output logic          busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] count_n;
  logic [CW-1:0] act_term, act_term_n;
  logic [RW-1:0] act_rep, act_rep_n;
  logic [RW-1:0] pass, pass_n;

  logic [CW-1:0] fifo_mod [DEPTH];
  logic [RW-1:0] fifo_rep [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop;
  logic          terminal, last_pass, abort_req;

`ifdef MODSEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // FIFO status uses an extra wrap bit on each pointer to tell full from empty
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;

  // Outputs decode only registered state so there is no input-to-output path
  assign terminal  = (count == act_term);
  assign last_pass = (pass == act_rep);
  assign busy      = (state == RUN);
  assign wrap      = busy && terminal;
  assign cmd_done  = wrap && last_pass;

  // FIFO storage is written on accepted pushes; contents need no reset
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_mod[wr_ptr[AW-1:0]] <= cmd_mod;
      fifo_rep[wr_ptr[AW-1:0]] <= cmd_rep;
    end
  end

  // FIFO pointers; reset empties the queue and wins over a simultaneous push
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Next-state logic: count through each pass, chain commands without a bubble
  always_comb begin
    state_n    = state;
    count_n    = count;
    pass_n     = pass;
    act_term_n = act_term;
    act_rep_n  = act_rep;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) pop = 1'b1;
      end
      RUN: begin
        if (abort_req) begin
          count_n = '0;
          pass_n  = '0;
          if (!empty) pop = 1'b1;
          else        state_n = IDLE;
        end else if (!terminal) begin
          count_n = count + 1'b1;
        end else begin
          count_n = '0;
          if (!last_pass) begin
            pass_n = pass + 1'b1;
          end else if (!empty) begin
            pop = 1'b1;
          end else begin
            pass_n  = '0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (pop) begin
      state_n    = RUN;
      count_n    = '0;
      pass_n     = '0;
      act_term_n = fifo_mod[rd_ptr[AW-1:0]] - 1'b1;
      act_rep_n  = fifo_rep[rd_ptr[AW-1:0]];
    end
  end

  // Control and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      pass     <= '0;
      act_term <= '0;
      act_rep  <= '0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      pass     <= pass_n;
      act_term <= act_term_n;
      act_rep  <= act_rep_n;
    end
  end

endmodule

// File: tb/tb_modulus_seq_ctrl.sv
// Testbench for modulus_seq_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the command sequencer.
module tb_modulus_seq_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [5:0] cmd_mod = '0;
  logic [3:0] cmd_rep = '0;
  logic       abort_s = 1'b0;
  logic [5:0] count;
  logic       wrap, cmd_done, busy;

  int checks = 0;
  int fails  = 0;

  // Reference model: pending commands plus an index k into the running one
  int  qmod[$];
  int  qrep[$];
  bit  m_busy = 0;
  int  m_k = 0;
  int  m_mod = 1;
  int  m_total = 1;

  wire [9:0] obs = {count, wrap, cmd_done, busy, cmd_ready};

  modulus_seq_ctrl #(.CW(6), .RW(4), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_mod(cmd_mod),
    .cmd_rep(cmd_rep),
`ifdef MODSEQ_ABORT_EN
    .abort(abort_s),
`endif
    .count(count),
    .wrap(wrap),
    .cmd_done(cmd_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Expected outputs: count is k mod M, wrap on the last value of a pass,
  // done on the very last cycle of the command
  function automatic logic [9:0] expv();
    int c;
    logic [5:0] c6;
    c  = m_busy ? (m_k % m_mod) : 0;
    c6 = c[5:0];
    return {c6, (m_busy && (c == m_mod - 1)), (m_busy && (m_k == m_total - 1)),
            m_busy, (qmod.size() < DEPTH)};
  endfunction

  function automatic void model_load();
    int md, rp;
    md = qmod.pop_front();
    rp = qrep.pop_front();
    m_mod   = md;
    m_total = md * (rp + 1);
    m_k     = 0;
    m_busy  = 1;
  endfunction

  // One clock: drive inputs, advance DUT and model across the edge
  task automatic step(input logic v, input logic [5:0] md, input logic [3:0] rp,
                      input logic r, input logic ab);
    bit push_ok;
    cmd_valid = v;
    cmd_mod   = md;
    cmd_rep   = rp;
    rst       = r;
    abort_s   = ab;
    push_ok   = v && !r && (qmod.size() < DEPTH);
    @(posedge clk);
    if (r) begin
      qmod.delete();
      qrep.delete();
      m_busy = 0;
      m_k    = 0;
    end else begin
      if (!m_busy) begin
        if (qmod.size() > 0) model_load();
      end else if (ab) begin
        if (qmod.size() > 0) model_load();
        else m_busy = 0;
      end else if (m_k == m_total - 1) begin
        if (qmod.size() > 0) model_load();
        else m_busy = 0;
      end else begin
        m_k++;
      end
      if (push_ok) begin
        qmod.push_back((md == 0) ? 64 : int'(md));
        qrep.push_back(int'(rp));
      end
    end
    #1;
    cmd_valid = 1'b0;
    rst       = 1'b0;
    abort_s   = 1'b0;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    checks++;
    if (obs !== 10'b0000000001) begin
      fails++;
      $display("[TB] FAIL reset_values got %b want %b", obs, 10'b0000000001);
    end
  endtask

  task automatic test_single();
    logic [9:0] want;
    step(1, 6'd10, 4'd1, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      want = {6'(i % 10), (i % 10) == 9, i == 19, 1'b1, 1'b1};
      checks++;
      if (obs !== want || obs !== expv()) begin
        fails++;
        $display("[TB] FAIL single cyc%0d got %b want %b model %b", i, obs, want, expv());
      end
      step(0, 0, 0, 0, 0);
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_end_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int seq[14] = '{0, 1, 2, 3, 4, 0, 1, 2, 0, 1, 2, 0, 1, 2};
    logic [5:0] c6;
    logic dn;
    step(1, 6'd5, 4'd0, 0, 0);
    step(1, 6'd3, 4'd2, 0, 0);
    for (int i = 0; i < 14; i++) begin
      c6 = seq[i][5:0];
      dn = (i == 4) || (i == 13);
      checks++;
      if (count !== c6 || cmd_done !== dn || busy !== 1'b1 || obs !== expv()) begin
        fails++;
        $display("[TB] FAIL b2b cyc%0d got count=%0d done=%b busy=%b want count=%0d done=%b",
                 i, count, cmd_done, busy, c6, dn);
      end
      step(0, 0, 0, 0, 0);
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_end_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_boundary();
    logic [9:0] want;
    step(1, 6'd1, 4'd3, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      want = {6'd0, 1'b1, i == 3, 1'b1, 1'b1};
      checks++;
      if (obs !== want || obs !== expv()) begin
        fails++;
        $display("[TB] FAIL mod1 cyc%0d got %b want %b", i, obs, want);
      end
      step(0, 0, 0, 0, 0);
    end
    step(1, 6'd0, 4'd0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) begin
      want = {6'(i), i == 63, i == 63, 1'b1, 1'b1};
      checks++;
      if (obs !== want || obs !== expv()) begin
        fails++;
        $display("[TB] FAIL mod64 cyc%0d got %b want %b", i, obs, want);
      end
      step(0, 0, 0, 0, 0);
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mod64_end_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_full();
    int mods[5] = '{2, 3, 4, 5, 6};
    int idx = 0;
    int dones = 0;
    bit saw_stall = 0;
    bit acc;
    logic [5:0] m6;
    step(1, 6'd20, 4'd0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int cyc = 0; cyc < 100 && idx < 5; cyc++) begin
      checks++;
      if (obs !== expv()) begin
        fails++;
        $display("[TB] FAIL full_fill cyc%0d got %b want %b", cyc, obs, expv());
      end
      if (cmd_ready === 1'b0) saw_stall = 1;
      if (cmd_done === 1'b1) dones++;
      acc = (qmod.size() < DEPTH);
      m6  = mods[idx][5:0];
      step(1, m6, 4'd0, 0, 0);
      if (acc) idx++;
    end
    checks++;
    if (idx != 5 || saw_stall != 1) begin
      fails++;
      $display("[TB] FAIL full_accept got accepted=%0d stalled=%0d want 5 and 1", idx, saw_stall);
    end
    for (int cyc = 0; cyc < 200 && (m_busy || qmod.size() > 0); cyc++) begin
      checks++;
      if (obs !== expv()) begin
        fails++;
        $display("[TB] FAIL full_drain cyc%0d got %b want %b", cyc, obs, expv());
      end
      if (cmd_done === 1'b1) dones++;
      step(0, 0, 0, 0, 0);
    end
    checks++;
    if (dones != 6 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL full_done_count got %0d busy=%b want 6 busy=0", dones, busy);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step(1, 6'd8, 4'd1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs !== 10'b0000000001 || obs !== expv()) begin
        fails++;
        $display("[TB] FAIL reset_mid cyc%0d got %b want %b", i, obs, 10'b0000000001);
      end
      step(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_random();
    logic v;
    logic [5:0] md;
    logic [3:0] rp;
    for (int i = 0; i < 400; i++) begin
      checks++;
      if (obs !== expv()) begin
        fails++;
        $display("[TB] FAIL random cyc%0d got %b want %b", i, obs, expv());
      end
      v  = ($urandom_range(0, 2) == 0);
      md = 6'($urandom_range(1, 7));
      rp = 4'($urandom_range(0, 2));
      step(v, md, rp, 0, 0);
    end
    for (int i = 0; i < 300 && (m_busy || qmod.size() > 0); i++) step(0, 0, 0, 0, 0);
    checks++;
    if (obs !== expv()) begin
      fails++;
      $display("[TB] FAIL random_drain got %b want %b", obs, expv());
    end
  endtask

`ifdef MODSEQ_ABORT_EN
  task automatic test_abort();
    int dones = 0;
    step(1, 6'd20, 4'd0, 0, 0);
    step(1, 6'd4, 4'd0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0);
    checks++;
    if (count !== 6'd7) begin
      fails++;
      $display("[TB] FAIL abort_pre got count=%0d want 7", count);
    end
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (count !== 6'(i) || cmd_done !== (i == 3) || obs !== expv()) begin
        fails++;
        $display("[TB] FAIL abort_next cyc%0d got count=%0d done=%b want %0d", i, count, cmd_done, i);
      end
      if (cmd_done === 1'b1) dones++;
      step(0, 0, 0, 0, 0);
    end
    checks++;
    if (dones != 1 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abort_done got dones=%0d busy=%b want 1 and 0", dones, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_boundary();
    test_full();
    test_reset_mid();
`ifdef MODSEQ_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
